// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single data memory. Each
// ownership is capped at MAX_BURST accepted cycles while the other port waits.
module dmem_arbiter_rport #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          acc,
    input  logic          we,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rdata,
    output logic          rvalid
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= acc && !we;
            if (acc && !we)
                rdata <= mem_rdata;
        end
    end
endmodule

module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic [DW-1:0] rdata0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic [DW-1:0] rdata1,
    output logic          rvalid1,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t            state, nxt;
    logic [CW-1:0]     cnt;
    logic              ptr;  // 0: port 0 wins a tie in IDLE
    logic [1:0]        req, we, acc, rvalid;
    logic [1:0][DW-1:0] rdata;

    assign req = {req1, req0};
    assign we  = {we1, we0};
    assign acc = req & {gnt1, gnt0};

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || !ptr)) nxt = OWN0;
                else if (req1)               nxt = OWN1;
            end
            OWN0: begin
                if (!req0)                   nxt = req1 ? OWN1 : IDLE;
                else if (req1 && cnt == LAST) nxt = OWN1;
            end
            OWN1: begin
                if (!req1)                   nxt = req0 ? OWN0 : IDLE;
                else if (req0 && cnt == LAST) nxt = OWN0;
            end
            default: nxt = IDLE;
        endcase
    end

    // Count saturates at LAST so a port that arrives after a long solo
    // ownership gets the memory on the very next edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            cnt   <= '0;
            ptr   <= 1'b0;
        end else begin
            state <= nxt;
            gnt0  <= (nxt == OWN0);
            gnt1  <= (nxt == OWN1);
            if (nxt != state)
                cnt <= '0;
            else if (|acc && cnt != LAST)
                cnt <= cnt + CW'(1);
            if (nxt != state && nxt == OWN0) ptr <= 1'b1;
            if (nxt != state && nxt == OWN1) ptr <= 1'b0;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            OWN0: begin
                mem_we    = req0 && we0;
                mem_addr  = addr0;
                mem_wdata = wdata0;
            end
            OWN1: begin
                mem_we    = req1 && we1;
                mem_addr  = addr1;
                mem_wdata = wdata1;
            end
            default: ;
        endcase
    end

    for (genvar p = 0; p < 2; p++) begin : g_rport
        dmem_arbiter_rport #(.DW(DW)) u_rport (
            .clk       (clk),
            .reset     (reset),
            .acc       (acc[p]),
            .we        (we[p]),
            .mem_rdata (mem_rdata),
            .rdata     (rdata[p]),
            .rvalid    (rvalid[p])
        );
    end

    assign rdata0  = rdata[0];
    assign rdata1  = rdata[1];
    assign rvalid0 = rvalid[0];
    assign rvalid1 = rvalid[1];
endmodule
